// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM states shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
endpackage

// File: rtl/lsu_mem_port_align.sv
// lsu_align: byte-lane strobes, store replication, load extension and request checks
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    illegal = we ? (funct3 != F3_B && funct3 != F3_H && funct3 != F3_W)
                 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
    wstrb = !we                   ? 4'b0000 :
            funct3[1:0] == 2'b00 ? 4'b0001 << addr :
            funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rdata_ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RV32 load/store unit driving a valid/ready word RAM
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);
  state_t      state;
  logic        q_we;
  logic [2:0]  q_f3;
  logic [1:0]  q_a;
  logic        a_we;
  logic [2:0]  a_f3;
  logic [1:0]  a_addr;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_mis;
  logic        a_ill;
  logic        unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH];
  assign req_ready = state == IDLE && !rst;
  // one aligner serves both the incoming request and the latched load in BUS
  assign a_we   = state == IDLE ? req_we : q_we;
  assign a_f3   = state == IDLE ? req_funct3 : q_f3;
  assign a_addr = state == IDLE ? req_addr[1:0] : q_a;
  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_f3),
    .addr       (a_addr),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wstrb      (a_wstrb),
    .wdata_rep  (a_wdata),
    .rdata_ext  (a_rdata),
    .misaligned (a_mis),
    .illegal    (a_ill)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q_we       <= 1'b0;
      q_f3       <= 3'b000;
      q_a        <= 2'b00;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'b0000;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          q_we <= req_we;
          q_f3 <= req_funct3;
          q_a  <= req_addr[1:0];
          if (a_mis || a_ill) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= BUS;
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= a_wdata;
            mem_wstrb <= a_wstrb;
          end
        end
        BUS: if (mem_ready) begin
          state      <= RESP;
          mem_valid  <= 1'b0;
          mem_wstrb  <= 4'b0000;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= q_we ? 32'h0 : a_rdata;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized and directed checks of lsu_mem_port against a byte-level memory model
module tb_lsu_mem_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_w [0:63];
  logic [7:0]  ref_b [0:255];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  lsu_mem_port #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_w[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en) mem_w[pl_idx] <= pl_val;
    else if (mem_valid && mem_ready)
      for (int l = 0; l < 4; l++)
        if (mem_wstrb[l]) mem_w[mem_addr[7:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) ref_b[{a[7:2], 2'b00} + i] = v[8*i +: 8];
    pl_idx = a[7:2];
    pl_val = v;
    pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // model: request-level semantics over a byte array, then cycle-level expectations
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits,
                        input logic pin, input logic [31:0] pin_v, input logic [3:0] pin_ws);
    int n;
    logic bad;
    logic [31:0] exp_rd, exp_wd, v;
    logic [3:0] exp_ws;
    logic [7:0] off;
    n = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (!bad && (addr % n) != 0) bad = 1'b1;
    off = addr[7:0];
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    exp_ws = 4'b0000;
    if (!bad) begin
      if (we) begin
        exp_ws = 4'(((1 << n) - 1) << addr[1:0]);
        exp_wd = n == 1 ? {4{wd[7:0]}} : n == 2 ? {2{wd[15:0]}} : wd;
        for (int i = 0; i < n; i++) ref_b[off + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[off + i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        exp_rd = v;
      end
    end
    if (pin) begin
      check("pin_model_data", we ? exp_wd : (bad ? resp_rdata & 32'h0 : exp_rd), pin_v);
      if (we && !bad) check("pin_model_wstrb", 32'(exp_ws), 32'(pin_ws));
    end
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (bad) begin
      check("err_resp_valid", 32'(resp_valid), 32'd1);
      check("err_resp_err", 32'(resp_err), 32'd1);
      check("err_resp_rdata", resp_rdata, 32'h0);
      check("err_no_mem_valid", 32'(mem_valid), 32'd0);
      @(negedge clk);
      check("err_resp_drop", 32'(resp_valid), 32'd0);
      check("err_no_mem_valid2", 32'(mem_valid), 32'd0);
      check("err_req_ready", 32'(req_ready), 32'd1);
    end else begin
      for (int j = 0; j <= waits; j++) begin
        check("bus_mem_valid", 32'(mem_valid), 32'd1);
        check("bus_mem_addr", 32'(mem_addr), 32'(addr[15:0] & 16'hFFFC));
        check("bus_mem_wstrb", 32'(mem_wstrb), 32'(exp_ws));
        if (we) check("bus_mem_wdata", mem_wdata, exp_wd);
        check("bus_req_ready", 32'(req_ready), 32'd0);
        check("bus_resp_valid", 32'(resp_valid), 32'd0);
        mem_ready = (j == waits);
        @(negedge clk);
      end
      mem_ready = 1'b0;
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_err", 32'(resp_err), 32'd0);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_mem_valid", 32'(mem_valid), 32'd0);
      check("resp_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("resp_drop", 32'(resp_valid), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    do_req(1'b1, 3'b010, 32'h0104, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 4'b1111);
    do_req(1'b1, 3'b000, 32'h0103, 32'h000000A5, 0, 1'b1, 32'hA5A5A5A5, 4'b1000);
    do_req(1'b1, 3'b001, 32'h0102, 32'h00001234, 1, 1'b1, 32'h12341234, 4'b1100);
    preload(8'h00, 32'h80112233);
    do_req(1'b0, 3'b000, 32'h0103, 32'h0, 0, 1'b1, 32'hFFFFFF80, 4'b0000);
    do_req(1'b0, 3'b100, 32'h0103, 32'h0, 0, 1'b1, 32'h00000080, 4'b0000);
    do_req(1'b0, 3'b001, 32'h0102, 32'h0, 2, 1'b1, 32'hFFFF8011, 4'b0000);
    do_req(1'b0, 3'b101, 32'h0102, 32'h0, 0, 1'b1, 32'h00008011, 4'b0000);
    do_req(1'b0, 3'b000, 32'h0100, 32'h0, 0, 1'b1, 32'h00000033, 4'b0000);
    do_req(1'b0, 3'b010, 32'h0100, 32'h0, 0, 1'b1, 32'h80112233, 4'b0000);
    do_req(1'b0, 3'b010, 32'h0102, 32'h0, 0, 1'b1, 32'h0, 4'b0000);
    do_req(1'b1, 3'b001, 32'h0101, 32'h5555, 0, 1'b0, 32'h0, 4'b0000);
    do_req(1'b0, 3'b011, 32'h0100, 32'h0, 0, 1'b0, 32'h0, 4'b0000);
    do_req(1'b1, 3'b010, 32'h0108, 32'hCAFEF00D, 3, 1'b1, 32'hCAFEF00D, 4'b1111);
    do_req(1'b0, 3'b010, 32'h0108, 32'h0, 0, 1'b1, 32'hCAFEF00D, 4'b0000);
    // reset while a load is waiting on memory
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h0100;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstbus_mem_valid_before", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_mem_valid", 32'(mem_valid), 32'd0);
    check("rstbus_resp_valid", 32'(resp_valid), 32'd0);
    check("rstbus_resp_rdata", resp_rdata, 32'h0);
    check("rstbus_req_ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("rstbus_req_ready_after", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h0100, 32'h0, 1, 1'b1, 32'h80112233, 4'b0000);
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      do_req(1'(r[0] ^ r[9]), 3'($urandom_range(0, 7)), {r[31:16], 8'h01, r[7:0]},
             $urandom, int'($urandom_range(0, 3)), 1'b0, 32'h0, 4'b0000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the word-addressed data RAM.
- Accepts one RV32 load/store request at a time from the core, checks alignment, and builds the byte-lane strobes and replicated write data.
- Drives the RAM's valid/ready port, then extracts and sign- or zero-extends load data.
- Returns a single-cycle response pulse to the core.

Parameters:
- ADDR_WIDTH, 16: number of address bits driven to memory; `req_addr` bits above this are ignored.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request, qualified by `resp_valid`
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts/completes the request
- mem_addr  out  ADDR_WIDTH  word-aligned byte address, low 2 bits always 0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write enables; 0000 for loads
- mem_rdata  in  32  memory read word, valid while `mem_valid & mem_ready`

Behaviour:
- FSM states: IDLE, BUS, RESP.
  - `req_ready` = (state == IDLE) & !rst. It decodes from state only, with no combinational path from `mem_ready`.
- IDLE, on `req_valid & req_ready`: latch we, funct3, addr, wdata.
  - Legal and aligned: go to BUS.
  - Otherwise: go to RESP with err = 1, and no memory access occurs.
- Illegal requests:
  - Loads with funct3 011, 110 or 111.
  - Stores with funct3 other than 000, 001 or 010.
- Misaligned requests:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
- BUS:
  - `mem_valid` = 1. `mem_addr`, `mem_wdata` and `mem_wstrb` are registered and held stable until `mem_ready`.
  - When `mem_ready` = 1: capture formatted load data into `resp_rdata`, then go to RESP.
  - Wait indefinitely while `mem_ready` = 0.
- RESP: `resp_valid` = 1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Latency, with edge E being the accepting edge:
  - `mem_valid` is high in the cycle after E.
  - With zero-wait memory, `resp_valid` is high in the cycle after E+1.
  - Error responses are visible the cycle after E.
  - Peak throughput is 1 access per 3 cycles.
- Store formatting:
  - B: `wdata` = {4{b}}, `wstrb` = 0001 << addr[1:0].
  - H: `wdata` = {2{h}}, `wstrb` = 0011 << {addr[1],0}.
  - W: passthrough data, `wstrb` = 1111.
- Load formatting:
  - Select the byte at lane addr[1:0], or the half at addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passthrough.
- Outputs outside BUS: `mem_valid` = 0 and `mem_wstrb` = 0000; `mem_addr` and `mem_wdata` hold their last value.
- `resp_rdata` and `resp_err` hold until the next response. Consumers qualify them with `resp_valid`.
- Reset values: state IDLE, `mem_valid` 0, `mem_wstrb` 0, `mem_addr` 0, `mem_wdata` 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `req_ready` 0 while `rst` is high.
- Reset mid-BUS: `mem_valid` drops at the reset edge. No response is issued and the request is lost.
  - Memory samples writes on `valid & ready`, so a store whose `mem_ready` coincided with that edge is already committed. Verification accepts either outcome.
- `req_valid` while not in IDLE is ignored (`req_ready` = 0), and the core must hold the request.

Decomposition:
- Package `lsu_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, BUS, RESP.
- Sub-module `lsu_align`, purely combinational, takes we/funct3/addr[1:0]/wdata/rdata and produces:
  - `wstrb`
  - replicated `wdata`
  - extended `rdata`
  - `misaligned`
  - `illegal`
- `lsu_mem_port` holds the FSM and all registers.

Test Plan:
- SW addr 0x0104, data 0xDEADBEEF, zero-wait memory -> `mem_addr` 0x0104, `wstrb` 1111, `wdata` 0xDEADBEEF; `resp_valid` 2 cycles after accept; err 0, rdata 0.
- SB addr 0x0103, data 0x000000A5 -> `wstrb` 1000, `wdata` 0xA5A5A5A5. SH addr 0x0102, data 0x1234 -> `wstrb` 1100, `wdata` 0x12341234.
- `mem_rdata` 0x80112233:
  - LB 0x0103 -> 0xFFFFFF80.
  - LBU 0x0103 -> 0x00000080.
  - LH 0x0102 -> 0xFFFF8011.
  - LHU 0x0102 -> 0x00008011.
  - LB 0x0100 -> 0x00000033.
  - LW 0x0100 -> 0x80112233.
- Error cases: LW 0x0102, SH 0x0101, load with funct3 011 -> `mem_valid` never asserts; `resp_valid` 1 cycle after accept with err 1 and rdata 0.
- `mem_ready` held low 3 cycles during SW -> `mem_valid`, `mem_addr`, `mem_wdata`, `mem_wstrb` stable all 4 cycles; `req_ready` 0 throughout; `resp_valid` the cycle after `mem_ready` is sampled high.
- `rst` asserted in BUS -> next cycle `mem_valid` 0, `resp_valid` 0, `resp_rdata` 0; `req_ready` 1 the first cycle after `rst` is released; the next LW completes normally.
